mux_stream_rr: RTL and testbench

MUX_STREAM_RR -- requirements
Module: mux_stream_rr

---
 rtl/mux_stream_rr_pkg.sv | 26 ++
 rtl/mux_stream_rr_arbiter.sv | 40 ++++
 rtl/mux_stream_rr.sv | 113 +++++++++++
 tb/tb_mux_stream_rr.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mux_stream_rr_pkg.sv
// ---------------------------------------------------------------------------
// mux_stream_rr_pkg
// Shared constants and helpers for the stream multiplexer:
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input
//   state_e              : output-register occupancy state
//   clog2()              : ceiling log2, never below 1 (select width)
// ---------------------------------------------------------------------------
package mux_stream_rr_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   // A one-bit select is kept even for N=1 so port widths never collapse.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/mux_stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin search. It returns the first requester
// found when searching ptr+1, ptr+2, ... modulo N.
// Ports:
//   req       in  N   request vector
//   ptr       in  SW  index of the most recently granted channel
//   gnt_idx   out SW  winning channel (0 when gnt_valid=0)
//   gnt_valid out 1   at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
   import mux_stream_rr_pkg::*;
#(
   parameter  int N  = 4,
   localparam int SW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [SW-1:0] gnt_idx,
   output logic          gnt_valid
);

   logic [SW-1:0] k;

   // The loop walks from the farthest offset down to the nearest one, so the
   // last hit written (the nearest to ptr+1) wins without needing a break.
   always_comb begin
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      k         = '0;
      for (int off = N; off >= 1; off--) begin
         k = SW'((int'(ptr) + off) % N);
         if (req[k]) begin
            gnt_idx   = k;
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_stream_rr.sv
// ---------------------------------------------------------------------------
// mux_stream_rr
// N-channel valid/ready stream multiplexer feeding a single output register.
// The source channel is either a fixed select (s) or a round-robin choice.
// Ports:
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   mode           0 = fixed select on s, 1 = round-robin
//   s              channel select for fixed mode
//   i_valid/i_data per-channel stream inputs (channel k at [k*W +: W])
//   i_ready        per-channel accept, combinational, at most one hot
//   y_valid/y_data registered output word, y_chan its source channel
//   y_ready        downstream accept
// ---------------------------------------------------------------------------
module mux_stream_rr
   import mux_stream_rr_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int W  = 8,
   localparam int SW = clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           mode,
   input  logic [SW-1:0]  s,
   input  logic [N-1:0]   i_valid,
   input  logic [N*W-1:0] i_data,
   output logic [N-1:0]   i_ready,
   output logic           y_valid,
   output logic [W-1:0]   y_data,
   output logic [SW-1:0]  y_chan,
   input  logic           y_ready
);

   state_e        state_q, state_d;
   logic [W-1:0]  y_data_q, y_data_d;
   logic [SW-1:0] y_chan_q, y_chan_d;
   logic [SW-1:0] ptr_q, ptr_d;

   logic [W-1:0]  ch_data [N];
   logic [SW-1:0] rr_idx;
   logic          rr_valid;
   logic [SW-1:0] cand_idx;
   logic          grant_valid;
   logic          load_en;

   for (genvar k = 0; k < N; k++) begin : g_slice
      assign ch_data[k] = i_data[k*W +: W];
   end

   rr_arbiter #(.N(N)) u_arb (
      .req       (i_valid),
      .ptr       (ptr_q),
      .gnt_idx   (rr_idx),
      .gnt_valid (rr_valid)
   );

   // Candidate selection is purely combinational on the current inputs, so
   // a channel that drops valid simply stops winning; nothing is reserved.
   always_comb begin
      cand_idx    = '0;
      grant_valid = 1'b0;
      if (mode == MODE_RR) begin
         cand_idx    = rr_idx;
         grant_valid = rr_valid;
      end else begin
         cand_idx    = s;
         grant_valid = (int'(s) < N) && i_valid[s];
      end
   end

   assign y_valid = (state_q == ST_FULL);
   assign y_data  = y_data_q;
   assign y_chan  = y_chan_q;
   assign load_en = (!y_valid || y_ready) && grant_valid;

   // Suppressed during reset so no upstream word is consumed and then lost.
   always_comb begin
      i_ready = '0;
      if (load_en && !rst) i_ready[cand_idx] = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      y_data_d = y_data_q;
      y_chan_d = y_chan_q;
      ptr_d    = ptr_q;
      if (load_en) begin
         // Covers both EMPTY->FULL and the back-to-back FULL->FULL case.
         state_d  = ST_FULL;
         y_data_d = ch_data[cand_idx];
         y_chan_d = cand_idx;
         if (mode == MODE_RR) ptr_d = cand_idx;
      end else if (state_q == ST_FULL && y_ready) begin
         state_d = ST_EMPTY;
      end
   end

   // ptr resets to N-1 so the first round-robin search starts at channel 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         y_data_q <= '0;
         y_chan_q <= '0;
         ptr_q    <= SW'(N - 1);
      end else begin
         state_q  <= state_d;
         y_data_q <= y_data_d;
         y_chan_q <= y_chan_d;
         ptr_q    <= ptr_d;
      end
   end

endmodule

// File: tb/tb_mux_stream_rr.sv
module tb_mux_stream_rr;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         mode;
   logic [1:0]   s;
   logic [N-1:0] i_valid;
   logic [N*W-1:0] i_data;
   logic [N-1:0] i_ready;
   logic         y_valid;
   logic [W-1:0] y_data;
   logic [1:0]   y_chan;
   logic         y_ready;

   int tests = 0;
   int fails = 0;

   // Reference model: the output register contents and the round-robin
   // pointer, plus an ordered queue of every word accepted.
   bit         m_full;
   logic [7:0] m_data;
   int         m_chan;
   int         m_ptr;
   logic [9:0] sbq[$];
   int         wt[N];

   mux_stream_rr #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .mode(mode), .s(s),
      .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
      .y_valid(y_valid), .y_data(y_data), .y_chan(y_chan), .y_ready(y_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_full = 0; m_data = '0; m_chan = 0; m_ptr = N - 1;
      sbq.delete();
      foreach (wt[k]) wt[k] = 0;
   endtask

   // Which channel the rules say should win this cycle.
   task automatic model_grant(output bit gv, output int g);
      gv = 0; g = 0;
      if (mode == 1'b0) begin
         g  = int'(s);
         gv = (g < N) && i_valid[g];
      end else begin
         for (int off = 1; off <= N && !gv; off++) begin
            if (i_valid[(m_ptr + off) % N]) begin
               gv = 1;
               g  = (m_ptr + off) % N;
            end
         end
      end
   endtask

   // One clock: inputs are already driven just after a falling edge.
   task automatic cyc();
      bit ld; bit gv; int g;
      logic xo; logic [7:0] od; logic [1:0] oc; logic [7:0] d; logic [9:0] fr;
      #1;
      model_grant(gv, g);
      ld = (!m_full || y_ready) && gv;
      chk("i_ready", 64'(i_ready), 64'(ld ? (4'b0001 << g) : 4'b0000));
      xo = y_valid & y_ready; od = y_data; oc = y_chan;
      for (int k = 0; k < N; k++) if (!i_valid[k] || !mode) wt[k] = 0;
      if (mode && i_ready != '0) begin
         for (int k = 0; k < N; k++) begin
            if (i_ready[k]) wt[k] = 0;
            else if (i_valid[k]) begin
               wt[k]++;
               chk("rr_wait_bound", 64'(wt[k] < N), 64'd1);
            end
         end
      end
      @(posedge clk);
      if (xo) begin
         chk("sb_nonempty", 64'(sbq.size() > 0), 64'd1);
         if (sbq.size() > 0) begin
            fr = sbq.pop_front();
            chk("sb_order", 64'({oc, od}), 64'(fr));
         end
      end
      if (ld) begin
         d = i_data[g*W +: W];
         sbq.push_back({2'(g), d});
         m_full = 1; m_data = d; m_chan = g;
         if (mode) m_ptr = g;
      end else if (y_ready) m_full = 0;
      #1;
      chk("y_valid", 64'(y_valid), 64'(m_full));
      if (m_full) begin
         chk("y_data", 64'(y_data), 64'(m_data));
         chk("y_chan", 64'(y_chan), 64'(m_chan));
      end
      @(negedge clk);
   endtask

   int exp_seq[5] = '{0, 1, 2, 3, 0};

   initial begin
      rst = 1; mode = 0; s = 0; i_valid = '0; i_data = '0; y_ready = 0;
      model_reset();
      @(negedge clk); @(negedge clk);
      chk("rst_y_valid", 64'(y_valid), 64'd0);
      chk("rst_y_data",  64'(y_data),  64'd0);
      chk("rst_i_ready", 64'(i_ready), 64'd0);
      rst = 0;

      // Fixed select on channel 2, loaded on the first edge after reset.
      mode = 0; s = 2; i_valid = 4'b0100; i_data = 32'h00A5_0000; y_ready = 1;
      #1 chk("fix_i_ready", 64'(i_ready), 64'h4);
      #0 cyc();
      chk("fix_y_data", 64'(y_data), 64'hA5);
      chk("fix_y_chan", 64'(y_chan), 64'd2);

      // Round-robin over four always-valid channels.
      i_valid = 4'b0000; cyc();
      mode = 1; i_valid = 4'b1111; i_data = 32'h1312_1110;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("rr_seq_chan", 64'(y_chan), 64'(exp_seq[i]));
         chk("rr_seq_data", 64'(y_data), 64'(8'h10 + exp_seq[i]));
      end

      // Backpressure holds the word and blocks every input.
      i_valid = 4'b0000; cyc();
      i_valid = 4'b1010; cyc();
      chk("bp_first_chan", 64'(y_chan), 64'd1);
      y_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_i_ready", 64'(i_ready), 64'd0);
         #0 cyc();
         chk("bp_hold_chan", 64'(y_chan), 64'd1);
      end
      y_ready = 1; cyc();
      chk("bp_next_chan", 64'(y_chan), 64'd3);

      // Fixed select on an idle channel gives no grant.
      mode = 0; s = 1; i_valid = 4'b1101;
      cyc(); cyc();
      chk("fix_idle_valid", 64'(y_valid), 64'd0);
      s = 0; cyc();
      chk("fix_s0_chan", 64'(y_chan), 64'd0);

      // Asynchronous reset while holding a word.
      i_valid = 4'b0001; i_data = 32'h0000_005A; cyc();
      chk("pre_rst_data", 64'(y_data), 64'h5A);
      y_ready = 0; i_valid = 4'b0000;
      #2 rst = 1;
      #1;
      chk("async_rst_valid", 64'(y_valid), 64'd0);
      chk("async_rst_data",  64'(y_data),  64'd0);
      chk("async_rst_ready", 64'(i_ready), 64'd0);
      model_reset();
      @(negedge clk);
      rst = 0; mode = 1; i_valid = 4'b1111; i_data = 32'h4433_2211; y_ready = 1;
      cyc();
      chk("post_rst_chan", 64'(y_chan), 64'd0);

      // Random stress: round-robin only, then mixed modes.
      for (int c = 0; c < 300; c++) begin
         mode = 1; s = 2'($urandom); i_valid = 4'($urandom); i_data = $urandom;
         y_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      for (int c = 0; c < 300; c++) begin
         mode = 1'($urandom); s = 2'($urandom); i_valid = 4'($urandom); i_data = $urandom;
         y_ready = ($urandom_range(0, 2) != 0);
         cyc();
      end
      i_valid = 4'b0000; y_ready = 1;
      cyc(); cyc();
      chk("sb_drained", 64'(sbq.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
